// File: rtl/usb4_g4_pkg.sv
// Shared USB4 Gen4 constants and types for the SLOS PRBS11 generator and receiver.
// The LFSR step lives here so the generator and receiver cannot drift apart.
package usb4_g4_pkg;

    localparam int          LFSR_W     = 11;
    localparam int          OS_CNT_W   = 8;
    localparam int          SLOS_LEN   = 448;
    localparam logic [10:0] SEED_LANE0 = 11'h7FF;
    localparam logic [10:0] SEED_LANE1 = 11'h770;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One step of x^11 + x^9 + 1, shifting towards the MSB.
    function automatic logic [LFSR_W-1:0] prbs11Step(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], cur[10] ^ cur[8]};
    endfunction

endpackage

// File: rtl/prbs11_gen_g4_if.sv
// Scheduler-side bus of the Gen4 SLOS generator; the i_/o_ names are seen from the generator.
interface prbs11_gen_g4_if;
    import usb4_g4_pkg::*;

    logic                i_enable;
    logic                i_start;
    logic                i_stop;
    logic [OS_CNT_W-1:0] i_os_count;
    logic                o_data_out;
    logic                o_data_valid;
    logic                o_os_done;
    logic                o_busy;

    modport master (
        output i_enable, i_start, i_stop, i_os_count,
        input  o_data_out, o_data_valid, o_os_done, o_busy
    );

    modport slave (
        input  i_enable, i_start, i_stop, i_os_count,
        output o_data_out, o_data_valid, o_os_done, o_busy
    );

endinterface

// File: rtl/prbs11_lfsr.sv
// 11-bit PRBS11 register with seed load and shift enables; shared with the Gen4 receiver.
module prbs11_lfsr
    import usb4_g4_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = SEED_LANE0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_shift,
    output logic o_tap
);

    logic [LFSR_W-1:0] r_lfsr;

    // Load wins over shift so a reseed at an OS boundary never takes an extra step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= SEED;
        end else if (i_load) begin
            r_lfsr <= SEED;
        end else if (i_shift) begin
            r_lfsr <= prbs11Step(r_lfsr);
        end
    end

    assign o_tap = r_lfsr[LFSR_W-1];

endmodule

// File: rtl/prbs11_gen_g4.sv
// Gen4 SLOS transmitter: bursts of 448-bit PRBS11 ordered sets, started/stopped by the lane scheduler.
module prbs11_gen_g4
    import usb4_g4_pkg::*;
#(
    parameter bit lane0_lane1    = 1'b1,
    parameter int OS_LEN         = SLOS_LEN,
    parameter bit RESEED_EACH_OS = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    prbs11_gen_g4_if.slave  bus
);

    localparam logic [LFSR_W-1:0] SEED     = lane0_lane1 ? SEED_LANE0 : SEED_LANE1;
    localparam logic [8:0]        LAST_BIT = 9'(OS_LEN - 1);

    state_t              r_state;
    state_t              w_nextState;
    logic [8:0]          r_bitCnt;
    logic [OS_CNT_W-1:0] r_osCnt;
    logic [OS_CNT_W-1:0] r_osTgt;
    logic                r_stopPend;
    logic                w_lastBit;
    logic                w_accept;
    logic                w_abort;
    logic                w_endBurst;
    logic                w_lfsrLoad;
    logic                w_lfsrShift;
    logic                w_tap;

    assign w_lastBit = (r_state == RUN) && (r_bitCnt == LAST_BIT);

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        w_endBurst  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.i_start && bus.i_enable) begin
                    w_accept    = 1'b1;
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (!bus.i_enable) begin
                    w_abort     = 1'b1;
                    w_nextState = IDLE;
                end else if (w_lastBit &&
                             (((r_osTgt != '0) && (r_osCnt + 8'd1 == r_osTgt)) ||
                              r_stopPend || bus.i_stop)) begin
                    w_endBurst  = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // A stop that arrives on the boundary cycle is consumed by that boundary, not carried over.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_bitCnt   <= '0;
            r_osCnt    <= '0;
            r_osTgt    <= '0;
            r_stopPend <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_osTgt    <= bus.i_os_count;
                r_osCnt    <= '0;
                r_bitCnt   <= '0;
                r_stopPend <= 1'b0;
            end else if (r_state == RUN) begin
                if (w_abort) begin
                    r_bitCnt   <= '0;
                    r_stopPend <= 1'b0;
                end else begin
                    r_bitCnt   <= w_lastBit ? 9'd0 : r_bitCnt + 9'd1;
                    r_stopPend <= w_endBurst ? 1'b0 : (r_stopPend | bus.i_stop);
                    if (w_lastBit) begin
                        r_osCnt <= r_osCnt + 8'd1;
                    end
                end
            end
        end
    end

    assign w_lfsrLoad  = (r_state != RUN) || (w_nextState == IDLE) ||
                         (w_lastBit && RESEED_EACH_OS);
    assign w_lfsrShift = (r_state == RUN);

    prbs11_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_lfsrLoad),
        .i_shift (w_lfsrShift),
        .o_tap   (w_tap)
    );

    assign bus.o_data_valid = (r_state == RUN);
    assign bus.o_busy       = (r_state == RUN);
    assign bus.o_data_out   = (r_state == RUN) && w_tap;
    assign bus.o_os_done    = w_lastBit && bus.i_enable;

endmodule

// File: tb/tb_prbs11_gen_g4.sv
// Directed bench for prbs11_gen_g4: lane 0 free-running and lane 1 reseeding instances share clk/reset.
module tb_prbs11_gen_g4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] tbStart = 2'b00;
    logic [1:0] tbStop = 2'b00;
    logic [1:0] tbEnable = 2'b11;
    logic [7:0] tbCount0 = 8'd0;
    logic [7:0] tbCount1 = 8'd0;
    logic [1:0] obsValid, obsData, obsDone, obsBusy;

    int assertCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    prbs11_gen_g4_if bus0 ();
    prbs11_gen_g4_if bus1 ();

    assign bus0.i_start    = tbStart[0];
    assign bus0.i_stop     = tbStop[0];
    assign bus0.i_enable   = tbEnable[0];
    assign bus0.i_os_count = tbCount0;
    assign bus1.i_start    = tbStart[1];
    assign bus1.i_stop     = tbStop[1];
    assign bus1.i_enable   = tbEnable[1];
    assign bus1.i_os_count = tbCount1;

    assign obsValid = {bus1.o_data_valid, bus0.o_data_valid};
    assign obsData  = {bus1.o_data_out,   bus0.o_data_out};
    assign obsDone  = {bus1.o_os_done,    bus0.o_os_done};
    assign obsBusy  = {bus1.o_busy,       bus0.o_busy};

    prbs11_gen_g4 #(.lane0_lane1(1'b1), .OS_LEN(448), .RESEED_EACH_OS(1'b0)) dut0 (
        .clk (clk), .reset (reset), .bus (bus0)
    );

    prbs11_gen_g4 #(.lane0_lane1(1'b0), .OS_LEN(448), .RESEED_EACH_OS(1'b1)) dut1 (
        .clk (clk), .reset (reset), .bus (bus1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic setCount(input int sel, input logic [7:0] cnt);
        if (sel == 0) tbCount0 = cnt;
        else          tbCount1 = cnt;
    endtask

    // Starts a burst and follows it to the end, injecting stop/enable-drop/restart at given bit indices
    // while comparing every bit against an independent PRBS11 reference.
    task automatic applyStimulus(
        input  int         sel,
        input  logic [7:0] cnt,
        input  bit         stopWithStart,
        input  int         stopAt,
        input  int         dropAt,
        input  int         restartAt,
        input  int         maxCycles,
        output int         validCnt,
        output int         doneCnt,
        output int         firstDone,
        output int         secondDone,
        output int         bitErrs,
        output int         sideErrs,
        output logic [11:0] first12,
        output logic [11:0] second12,
        output bit         timedOut
    );
        logic [10:0] model;
        logic [10:0] seed;
        bit          reseed;
        bit          seen;
        seed     = (sel == 0) ? 11'h7FF : 11'h770;
        reseed   = (sel == 1);
        model    = seed;
        validCnt = 0; doneCnt = 0; firstDone = 0; secondDone = 0;
        bitErrs  = 0; sideErrs = 0; first12 = '0; second12 = '0;
        timedOut = 1'b1; seen = 1'b0;
        @(negedge clk);
        setCount(sel, cnt);
        tbStart[sel] = 1'b1;
        if (stopWithStart) tbStop[sel] = 1'b1;
        for (int c = 0; c < maxCycles; c++) begin
            @(negedge clk);
            tbStart[sel] = 1'b0;
            tbStop[sel]  = 1'b0;
            if (obsValid[sel]) begin
                seen = 1'b1;
                if (obsData[sel] !== model[10]) bitErrs++;
                if (obsBusy[sel] !== 1'b1) sideErrs++;
                if (validCnt < 12) first12[11 - validCnt] = obsData[sel];
                if (validCnt >= 448 && validCnt < 460) second12[459 - validCnt] = obsData[sel];
                if (obsDone[sel]) begin
                    doneCnt++;
                    if (firstDone == 0)       firstDone = validCnt + 1;
                    else if (secondDone == 0) secondDone = validCnt + 1;
                end
                if (reseed && (validCnt % 448 == 447)) model = seed;
                else model = {model[9:0], model[10] ^ model[8]};
                if (validCnt == stopAt) tbStop[sel] = 1'b1;
                if (validCnt == dropAt) tbEnable[sel] = 1'b0;
                if (validCnt == restartAt) begin
                    tbStart[sel] = 1'b1;
                    setCount(sel, 8'd5);
                end
                validCnt++;
            end else begin
                if (obsDone[sel] !== 1'b0 || obsBusy[sel] !== 1'b0 || obsData[sel] !== 1'b0) sideErrs++;
                if (seen) begin
                    timedOut = 1'b0;
                    break;
                end
            end
        end
        tbEnable[sel] = 1'b1;
    endtask

    initial begin
        int vc, dc, fd, sd, be, se;
        logic [11:0] f12, s12;
        bit to;

        $display("[TB] prbs11_gen_g4 directed run");
        repeat (3) @(negedge clk);
        checkOutput("rst_valid0", obsValid[0], 1'b0);
        checkOutput("rst_data0",  obsData[0],  1'b0);
        checkOutput("rst_done0",  obsDone[0],  1'b0);
        checkOutput("rst_busy",   obsBusy,     2'b00);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Lane 0, one ordered set.
        applyStimulus(0, 8'd1, 1'b0, -1, -1, -1, 2000, vc, dc, fd, sd, be, se, f12, s12, to);
        checkOutput("l0_first12", f12, 12'hFFE);
        checkOutput("l0_valid",   vc, 448);
        checkOutput("l0_done",    dc, 1);
        checkOutput("l0_donePos", fd, 448);
        checkOutput("l0_bits",    be, 0);
        checkOutput("l0_side",    se, 0);
        checkOutput("l0_timeout", to, 1'b0);

        // Lane 1 with per-OS reseed, two ordered sets.
        applyStimulus(1, 8'd2, 1'b0, -1, -1, -1, 3000, vc, dc, fd, sd, be, se, f12, s12, to);
        checkOutput("l1_first12",  f12, 12'hEE0);
        checkOutput("l1_second12", s12, 12'hEE0);
        checkOutput("l1_valid",    vc, 896);
        checkOutput("l1_done",     dc, 2);
        checkOutput("l1_donePos2", sd - fd, 448);
        checkOutput("l1_bits",     be, 0);
        checkOutput("l1_timeout",  to, 1'b0);

        // Continuous burst, stop at bit 100 of the third OS.
        applyStimulus(0, 8'd0, 1'b0, 996, -1, -1, 3000, vc, dc, fd, sd, be, se, f12, s12, to);
        checkOutput("stop_valid",   vc, 1344);
        checkOutput("stop_done",    dc, 3);
        checkOutput("stop_bits",    be, 0);
        checkOutput("stop_timeout", to, 1'b0);

        // Enable dropped at bit 200, then a fresh burst restarts from the seed.
        applyStimulus(0, 8'd1, 1'b0, -1, 200, -1, 2000, vc, dc, fd, sd, be, se, f12, s12, to);
        checkOutput("drop_valid", vc, 201);
        checkOutput("drop_done",  dc, 0);
        checkOutput("drop_side",  se, 0);
        applyStimulus(0, 8'd1, 1'b0, -1, -1, -1, 2000, vc, dc, fd, sd, be, se, f12, s12, to);
        checkOutput("redo_first12", f12, 12'hFFE);
        checkOutput("redo_valid",   vc, 448);

        // Start re-pulsed mid-burst with a larger count must not extend the burst.
        applyStimulus(0, 8'd2, 1'b0, -1, -1, 300, 4000, vc, dc, fd, sd, be, se, f12, s12, to);
        checkOutput("restart_valid", vc, 896);
        checkOutput("restart_done",  dc, 2);
        checkOutput("restart_bits",  be, 0);

        // Start and stop together in IDLE: stop ignored.
        applyStimulus(0, 8'd1, 1'b1, -1, -1, -1, 2000, vc, dc, fd, sd, be, se, f12, s12, to);
        checkOutput("startstop_valid", vc, 448);

        // Start with enable low is ignored.
        @(negedge clk);
        tbEnable[0] = 1'b0;
        tbCount0    = 8'd1;
        tbStart[0]  = 1'b1;
        @(negedge clk);
        tbStart[0]  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("noen_valid", obsValid[0], 1'b0);
        tbEnable[0] = 1'b1;

        // Asynchronous reset mid-burst.
        @(negedge clk);
        tbCount0   = 8'd0;
        tbStart[0] = 1'b1;
        @(negedge clk);
        tbStart[0] = 1'b0;
        repeat (50) @(negedge clk);
        checkOutput("arst_pre_valid", obsValid[0], 1'b1);
        #2 reset = 1'b0;
        #1;
        checkOutput("arst_valid", obsValid[0], 1'b0);
        checkOutput("arst_busy",  obsBusy[0],  1'b0);
        checkOutput("arst_data",  obsData[0],  1'b0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 8'd1, 1'b0, -1, -1, -1, 2000, vc, dc, fd, sd, be, se, f12, s12, to);
        checkOutput("arst_first12", f12, 12'hFFE);
        checkOutput("arst_bits",    be, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/prbs11_gen_g4.md
Name: prbs11_gen_g4

Overview:
- Gen4 transmit-side SLOS generator, upstream of the Gen4 PRBS11 ordered-set receiver.
- Produces a serial bitstream of 448-bit ordered sets from a PRBS11 LFSR (x^11 + x^9 + 1), seeded per lane.
- Driven by the lane training/ordered-set scheduler. Feeds the lane serializer, or the receiver directly in loopback.

Parameters:
- lane0_lane1, 1, 1 = lane 0 seed 11'h7FF; 0 = lane 1 seed 11'h770.
- OS_LEN, 448, bits per ordered set. Bit counter wraps at OS_LEN-1 (9'h1BF).
- RESEED_EACH_OS, 0, 0 = LFSR free-runs across OS boundaries; 1 = LFSR reloads the seed at each OS start.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-low
- enable  input  1  level; low aborts immediately and holds the block idle
- start  input  1  single-cycle request to begin a burst; honoured only in IDLE with enable=1
- os_count  input  8  number of ordered sets in the burst, sampled at start; 0 = run continuously until stop
- stop  input  1  single-cycle request to end the burst at the next OS boundary
- data_out  output  1  serial PRBS bit, MSB of LFSR
- data_valid  output  1  data_out is meaningful this cycle
- os_done  output  1  one-cycle pulse coincident with the last bit (bit 447) of each OS
- busy  output  1  high from the cycle after start is accepted until the burst ends

Behaviour:
- Reset:
  - data_out=0, data_valid=0, os_done=0, busy=0.
  - lfsr=seed, bit_cnt=0, os_cnt=0, stop_pend=0, state=IDLE.
- State IDLE:
  - Outputs 0; lfsr held at seed.
  - start & enable -> RUN. Latch os_count into os_tgt; clear os_cnt, bit_cnt and stop_pend.
- State RUN, every cycle:
  - data_valid=1, data_out=lfsr[10].
  - lfsr <= {lfsr[9:0], lfsr[10]^lfsr[8]}.
  - bit_cnt increments, wrapping 447->0.
- Latency: data_valid=1 on the cycle after start is sampled; the first bit is seed[10], which is 1 for both seeds.
- At bit_cnt==447:
  - os_done=1 and os_cnt increments (8-bit).
  - If RESEED_EACH_OS=1, lfsr <= seed instead of the shift.
  - End the burst (return to IDLE, busy=0, data_valid=0 the next cycle, lfsr <= seed) if either:
    - os_tgt!=0 and os_cnt+1==os_tgt, or
    - stop_pend, or stop asserted in this same cycle.
- stop:
  - In RUN, latched into stop_pend and honoured at the next boundary; the OS in progress is always completed.
  - Ignored in IDLE.
- start while busy: ignored; no effect on os_tgt.
- enable falling in RUN: next cycle state=IDLE with all outputs 0. No os_done for the partial OS; lfsr reseeded.
- Asynchronous reset mid-burst: immediate return to reset values.
- start and stop in the same IDLE cycle: start accepted, stop ignored.
- os_count=1: exactly one OS (448 valid cycles), then IDLE.
- With os_tgt=0 and no stop, the burst runs indefinitely; os_cnt wraps modulo 256 and does not stop the burst.

Decomposition:
- Shared package (usb4_g4_pkg): SEED_LANE0=11'h7FF, SEED_LANE1=11'h770, SLOS_LEN=448, and a 2-state enum (IDLE, RUN).
- One natural sub-module: prbs11_lfsr, holding the 11-bit register with load and shift enables and a tap output. The receiver team reuses it.

Test Plan:
- Lane 0, os_count=1, start -> first 12 data_out bits 1,1,1,1,1,1,1,1,1,1,1,0; exactly 448 data_valid cycles; one os_done on cycle 448; busy drops after it.
- Lane 1 (lane0_lane1=0), os_count=2 -> first 11 bits 1,1,1,0,1,1,1,0,0,0,0; 896 valid cycles; os_done twice, 448 cycles apart.
- os_count=0, stop pulsed at bit 100 of the 3rd OS -> the 3rd OS completes; 1344 valid cycles total; then IDLE.
- enable dropped at bit 200 of the 1st OS -> data_valid=0 next cycle, no os_done, busy=0. A new start yields a first bit of 1 and the seed sequence again.
- start re-pulsed mid-burst with os_count=5 while the original os_count=2 -> burst still ends after 2 OS.
- Loopback into the Gen4 PRBS11 receiver (same lane parameter), os_count=4, RESEED_EACH_OS=0 -> receiver os_rec pulses once per completed OS after the first, with no error.
